enet_tx_ctrl: RTL and testbench

Frame-level transmit sequencer for the ENET MAC. It moves bytes from the TX input FIFO to the TX output FIFO one frame at a time, and enforces the programmed maximum frame length by truncating babbling frames. It terminates frames cleanly when the MAC is disabled mid-frame, and implements graceful transmit stop. It sits between the ECR control register (ether_en, max_fl, gts) and the TX FIFO pair.

---
 rtl/enet_pkg.sv | 22 ++
 rtl/enet_tx_ctrl_ff_d_with_wen.sv | 18 +
 rtl/enet_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_enet_tx_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enet_pkg.sv
// Shared encodings for the ENET transmit sequencer: state values and
// FIFO word field positions.
package enet_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_XFER  = 3'd1;
  localparam logic [2:0] ST_ABORT = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    XFER  = ST_XFER,
    ABORT = ST_ABORT,
    DROP  = ST_DROP,
    STOP  = ST_STOP
  } tx_state_t;

  localparam int EOF_BIT = 8;
  localparam int ERR_BIT = 9;

endpackage

// File: rtl/enet_tx_ctrl_ff_d_with_wen.sv
// Write-enabled D register with async active-low clear; holds the
// per-frame length limit.
module FF_D_with_wen #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/enet_tx_ctrl.sv
// Frame-level TX sequencer: moves bytes from the input FIFO to the output
// FIFO, truncates at max_fl, aborts on disable and handles graceful stop.
//
// state | meaning
// IDLE  | between frames, waiting for data or a stop request
// XFER  | moving bytes one per cycle
// ABORT | MAC disabled mid-frame, writing the error terminator
// DROP  | discarding the rest of the input frame up to its eof
// STOP  | graceful stop reached, gra asserted
module enet_tx_ctrl
  import enet_pkg::*;
#(
  parameter int MAX_FL_W = 14,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ether_en,
  input  logic                gts,
  input  logic [MAX_FL_W-1:0] max_fl,
  input  logic                Tx_in_empty,
  input  logic [8:0]          tx_in_rdata,
  output logic                tx_in_ren,
  input  logic                Tx_out_full,
  output logic                tx_out_wen,
  output logic [9:0]          tx_out_wdata,
  output logic                gra,
  output logic                babt_pulse,
  output logic                txf_pulse,
  output logic [CNT_W-1:0]    tx_frame_cnt
);

  tx_state_t           state, state_nxt;
  logic [MAX_FL_W-1:0] byte_cnt, byte_cnt_p1, fl_lat;
  logic                fl_wen, cnt_clr, cnt_inc;
  logic                babt_nxt, txf_nxt, good_nxt;
  logic                in_eof;

  assign byte_cnt_p1 = byte_cnt + MAX_FL_W'(1);
  assign in_eof      = tx_in_rdata[EOF_BIT];

  FF_D_with_wen #(.W(MAX_FL_W)) u_fl_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (fl_wen),
    .d     (max_fl),
    .q     (fl_lat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      babt_pulse   <= 1'b0;
      txf_pulse    <= 1'b0;
      gra          <= 1'b0;
      tx_frame_cnt <= '0;
    end else begin
      state      <= state_nxt;
      babt_pulse <= babt_nxt;
      txf_pulse  <= txf_nxt;
      // gra drops on the edge after gts falls, not a cycle later
      gra        <= (state == STOP) && gts;
      if (cnt_clr)      byte_cnt <= '0;
      else if (cnt_inc) byte_cnt <= byte_cnt_p1;
      if (good_nxt) tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_in_ren    = 1'b0;
    tx_out_wen   = 1'b0;
    tx_out_wdata = '0;
    fl_wen       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    babt_nxt     = 1'b0;
    txf_nxt      = 1'b0;
    good_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (gts) begin
          state_nxt = STOP;
        end else if (ether_en && !Tx_in_empty) begin
          state_nxt = XFER;
          fl_wen    = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      XFER: begin
        if (!ether_en) begin
          state_nxt = ABORT;
        end else if (!Tx_in_empty && !Tx_out_full) begin
          tx_in_ren    = 1'b1;
          tx_out_wen   = 1'b1;
          cnt_inc      = 1'b1;
          tx_out_wdata = {1'b0, in_eof, tx_in_rdata[7:0]};
          if (in_eof) begin
            state_nxt = IDLE;
            txf_nxt   = 1'b1;
            good_nxt  = 1'b1;
          end else if (byte_cnt_p1 == fl_lat) begin
            // fl_lat of zero matches on wrap, i.e. at 2^MAX_FL_W bytes
            tx_out_wdata = {1'b1, 1'b1, tx_in_rdata[7:0]};
            state_nxt    = DROP;
            babt_nxt     = 1'b1;
            txf_nxt      = 1'b1;
          end
        end
      end
      ABORT: begin
        if (!Tx_out_full) begin
          tx_out_wen   = 1'b1;
          tx_out_wdata = {1'b1, 1'b1, 8'h00};
          txf_nxt      = 1'b1;
          state_nxt    = DROP;
        end
      end
      DROP: begin
        if (!Tx_in_empty) begin
          tx_in_ren = 1'b1;
          if (in_eof) state_nxt = IDLE;
        end
      end
      STOP: begin
        if (!gts) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enet_tx_ctrl.sv
// Self-checking bench for enet_tx_ctrl: FIFO models on both sides and a
// frame-level reference model of truncation/abort behaviour.
module tb_enet_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ether_en;
  logic        gts;
  logic [13:0] max_fl;
  logic        Tx_in_empty;
  logic [8:0]  tx_in_rdata;
  logic        tx_in_ren;
  logic        Tx_out_full;
  logic        tx_out_wen;
  logic [9:0]  tx_out_wdata;
  logic        gra;
  logic        babt_pulse;
  logic        txf_pulse;
  logic [15:0] tx_frame_cnt;

  enet_tx_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ether_en     (ether_en),
    .gts          (gts),
    .max_fl       (max_fl),
    .Tx_in_empty  (Tx_in_empty),
    .tx_in_rdata  (tx_in_rdata),
    .tx_in_ren    (tx_in_ren),
    .Tx_out_full  (Tx_out_full),
    .tx_out_wen   (tx_out_wen),
    .tx_out_wdata (tx_out_wdata),
    .gra          (gra),
    .babt_pulse   (babt_pulse),
    .txf_pulse    (txf_pulse),
    .tx_frame_cnt (tx_frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] in_q[$];
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];
  int full_mode = 0;
  int cyc = 0;
  int pops, babt_seen, txf_seen, wr_full_err, pop_empty_err;
  int exp_babt, exp_txf;
  int exp_cnt = 0;

  // One clock: drive FIFO flags away from the edge, then record what the
  // DUT does on the coming rising edge.
  task automatic cycle();
    logic full;
    @(negedge clk);
    case (full_mode)
      1:       full = cyc[0];
      2:       full = 1'($urandom_range(0, 1));
      3:       full = 1'b1;
      default: full = 1'b0;
    endcase
    Tx_out_full = full;
    Tx_in_empty = (in_q.size() == 0);
    tx_in_rdata = (in_q.size() == 0) ? 9'h000 : in_q[0];
    #1;
    if (tx_in_ren) begin
      if (in_q.size() == 0) pop_empty_err++;
      else in_q.delete(0);
      pops++;
    end
    if (tx_out_wen) begin
      if (full) wr_full_err++;
      out_q.push_back(tx_out_wdata);
    end
    if (babt_pulse) babt_seen++;
    if (txf_pulse)  txf_seen++;
    cyc++;
  endtask

  task automatic run_drain(input int budget, input string name);
    int n = 0;
    int idle = 0;
    while (idle < 4 && n < budget) begin
      cycle();
      n++;
      if (in_q.size() == 0) idle++;
      else idle = 0;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s drain timeout: left=%0d budget=%0d", name, in_q.size(), budget);
    end
  endtask

  task automatic run_until_writes(input int target, input int budget, input string name);
    int n = 0;
    while (out_q.size() < target && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s wait timeout: writes=%0d want=%0d", name, out_q.size(), target);
    end
  endtask

  // Reference: a frame of len bytes against limit lim is forwarded intact
  // when it ends within the limit, otherwise cut at lim with err+eof.
  task automatic add_frame(input int len, input int lim);
    logic [7:0] d;
    logic       eof;
    for (int i = 0; i < len; i++) begin
      d   = 8'($urandom_range(0, 255));
      eof = (i == len - 1);
      in_q.push_back({eof, d});
      if (len <= lim) exp_q.push_back({1'b0, eof, d});
      else if (i < lim) exp_q.push_back({(i == lim - 1), (i == lim - 1), d});
    end
    exp_txf++;
    if (len <= lim) exp_cnt++;
    else exp_babt++;
  endtask

  function automatic int first_diff();
    if (out_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic start_test();
    out_q.delete();
    exp_q.delete();
    pops = 0; babt_seen = 0; txf_seen = 0;
    exp_babt = 0; exp_txf = 0;
    wr_full_err = 0; pop_empty_err = 0;
  endtask

  task automatic check_frames(input string name);
    int d;
    d = first_diff();
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL %s data: diff_at=%0d got_n=%0d want_n=%0d", name, d, out_q.size(), exp_q.size());
    end
    total++;
    if (txf_seen != exp_txf || babt_seen != exp_babt) begin
      bad++;
      $display("FAIL %s pulses: txf=%0d/%0d babt=%0d/%0d", name, txf_seen, exp_txf, babt_seen, exp_babt);
    end
    total++;
    if (tx_frame_cnt !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL %s frame_cnt: got=%0d want=%0d", name, tx_frame_cnt, 16'(exp_cnt));
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({tx_in_ren, tx_out_wen, tx_out_wdata, gra, babt_pulse, txf_pulse, tx_frame_cnt} !== 30'd0) begin
      bad++;
      $display("FAIL reset outputs: got=%h want=0",
               {tx_in_ren, tx_out_wen, tx_out_wdata, gra, babt_pulse, txf_pulse, tx_frame_cnt});
    end
  endtask

  task automatic test_basic();
    start_test();
    full_mode = 0;
    max_fl = 14'd1518;
    add_frame(64, 1518);
    run_drain(200, "basic");
    check_frames("basic");
    total++;
    if (out_q.size() != 64 || out_q[out_q.size()-1][9:8] !== 2'b01) begin
      bad++;
      $display("FAIL basic last_word: n=%0d want n=64 with err=0 eof=1", out_q.size());
    end
  endtask

  task automatic test_truncate();
    start_test();
    full_mode = 0;
    max_fl = 14'd16;
    add_frame(20, 16);
    add_frame(8, 16);
    run_until_writes(1, 20, "trunc");
    max_fl = 14'd1518;
    run_drain(200, "trunc");
    check_frames("trunc");
    total++;
    if (pops != 28) begin
      bad++;
      $display("FAIL trunc pops: got=%0d want=28", pops);
    end
  endtask

  task automatic test_backpressure();
    start_test();
    full_mode = 1;
    max_fl = 14'd1518;
    add_frame(32, 1518);
    run_drain(300, "bp");
    check_frames("bp");
    total++;
    if (pops != out_q.size() || wr_full_err != 0 || pop_empty_err != 0) begin
      bad++;
      $display("FAIL bp handshake: pops=%0d writes=%0d wr_full=%0d pop_empty=%0d",
               pops, out_q.size(), wr_full_err, pop_empty_err);
    end
    full_mode = 0;
  endtask

  task automatic test_abort();
    logic [7:0] d;
    start_test();
    full_mode = 0;
    max_fl = 14'd1518;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      in_q.push_back({(i == 39), d});
      if (i < 10) exp_q.push_back({2'b00, d});
    end
    exp_q.push_back(10'h300);
    exp_txf = 1;
    run_until_writes(10, 40, "abort");
    ether_en = 1'b0;
    full_mode = 3;
    repeat (3) cycle();
    total++;
    if (out_q.size() != 10) begin
      bad++;
      $display("FAIL abort write_while_full: writes=%0d want=10", out_q.size());
    end
    full_mode = 0;
    run_drain(200, "abort");
    check_frames("abort");
    total++;
    if (pops != 40 || wr_full_err != 0) begin
      bad++;
      $display("FAIL abort drain: pops=%0d want=40 wr_full=%0d", pops, wr_full_err);
    end
    ether_en = 1'b1;
  endtask

  task automatic test_gts();
    start_test();
    full_mode = 0;
    max_fl = 14'd1518;
    add_frame(20, 1518);
    add_frame(20, 1518);
    run_until_writes(5, 40, "gts");
    gts = 1'b1;
    run_until_writes(20, 60, "gts");
    repeat (6) cycle();
    total++;
    if (gra !== 1'b1 || in_q.size() != 20 || out_q.size() != 20) begin
      bad++;
      $display("FAIL gts stopped: gra=%b queued=%0d writes=%0d want gra=1 queued=20 writes=20",
               gra, in_q.size(), out_q.size());
    end
    gts = 1'b0;
    cycle();
    cycle();
    total++;
    if (gra !== 1'b0) begin
      bad++;
      $display("FAIL gts release: gra=%b want=0", gra);
    end
    run_drain(200, "gts");
    check_frames("gts");
  endtask

  task automatic test_random();
    int len, lim;
    for (int f = 0; f < 8; f++) begin
      start_test();
      full_mode = 2;
      lim = $urandom_range(1, 90);
      len = $urandom_range(1, 80);
      max_fl = 14'(lim);
      add_frame(len, lim);
      run_drain(600, "random");
      check_frames("random");
    end
    full_mode = 0;
  endtask

  task automatic test_maxfl_zero();
    start_test();
    full_mode = 0;
    max_fl = 14'd0;
    add_frame(20000, 16384);
    run_drain(25000, "maxfl0");
    check_frames("maxfl0");
    total++;
    if (out_q.size() != 16384 || out_q[out_q.size()-1][9:8] !== 2'b11) begin
      bad++;
      $display("FAIL maxfl0 cut: writes=%0d want=16384 with err=1 eof=1", out_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    start_test();
    full_mode = 0;
    max_fl = 14'd1518;
    add_frame(50, 1518);
    run_until_writes(10, 30, "midrst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_in_ren, tx_out_wen, tx_out_wdata, gra, babt_pulse, txf_pulse} !== 14'd0) begin
      bad++;
      $display("FAIL midrst outputs: got=%h want=0",
               {tx_in_ren, tx_out_wen, tx_out_wdata, gra, babt_pulse, txf_pulse});
    end
    @(posedge clk);
    #1;
    total++;
    if ({tx_in_ren, tx_out_wen, tx_out_wdata, txf_pulse, tx_frame_cnt} !== 29'd0) begin
      bad++;
      $display("FAIL midrst after_edge: got=%h want=0",
               {tx_in_ren, tx_out_wen, tx_out_wdata, txf_pulse, tx_frame_cnt});
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    ether_en    = 1'b1;
    gts         = 1'b0;
    max_fl      = 14'd1518;
    Tx_in_empty = 1'b1;
    tx_in_rdata = 9'h000;
    Tx_out_full = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_truncate();
    test_backpressure();
    test_abort();
    test_gts();
    test_random();
    test_maxfl_zero();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
